// File: rtl/bus_cycle_sequencer.sv
// Memory bus cycle sequencer: arbitrates fetch vs data access and walks each
// access through SETUP -> STROBE -> DONE with a programmable wait-state count.
module bus_cycle_sequencer #(
   parameter int WAIT_STATES = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FETCH_REQ,
   output logic        FETCH_ACK,
   input  logic        DATA_REQ,
   input  logic        DATA_WR,
   input  logic [1:0]  DATA_SRC,
   output logic        DATA_ACK,
   input  logic        MEM_WAIT,
   input  logic [15:0] MEM_DATA_IN,
   output logic [15:0] RDATA,
   output logic [1:0]  ADDR_BUSX,
   output logic        MEM_RD,
   output logic        MEM_WR,
   output logic        BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;

   localparam logic [2:0] WS = 3'(WAIT_STATES);

   state_t     r_state;
   logic [2:0] r_cnt;
   logic       r_last_data;
   logic       r_op_fetch;
   logic       r_op_wr;
   logic       w_grant_fetch;

   // Under contention the side not served last wins; r_last_data=1 means data went last.
   assign w_grant_fetch = FETCH_REQ && (!DATA_REQ || r_last_data);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= S_IDLE;
         r_cnt       <= 3'd0;
         r_last_data <= 1'b1;
         r_op_fetch  <= 1'b0;
         r_op_wr     <= 1'b0;
         ADDR_BUSX   <= 2'd0;
         MEM_RD      <= 1'b0;
         MEM_WR      <= 1'b0;
         FETCH_ACK   <= 1'b0;
         DATA_ACK    <= 1'b0;
         BUSY        <= 1'b0;
         RDATA       <= 16'h0000;
      end else begin
         FETCH_ACK <= 1'b0;
         DATA_ACK  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (FETCH_REQ || DATA_REQ) begin
                  r_op_fetch <= w_grant_fetch;
                  r_op_wr    <= !w_grant_fetch && DATA_WR;
                  ADDR_BUSX  <= w_grant_fetch ? 2'd0 : DATA_SRC;
                  BUSY       <= 1'b1;
                  r_state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_cnt   <= WS;
               MEM_RD  <= !r_op_wr;
               MEM_WR  <= r_op_wr;
               r_state <= S_STROBE;
            end
            S_STROBE: begin
               if (r_cnt != 3'd0) begin
                  r_cnt <= r_cnt - 3'd1;
               end else if (!MEM_WAIT) begin
                  MEM_RD    <= 1'b0;
                  MEM_WR    <= 1'b0;
                  FETCH_ACK <= r_op_fetch;
                  DATA_ACK  <= !r_op_fetch;
                  if (!r_op_wr)
                     RDATA <= MEM_DATA_IN;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_last_data <= !r_op_fetch;
               ADDR_BUSX   <= 2'd0;
               BUSY        <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Self-checking bench for bus_cycle_sequencer: per-access timelines computed
// arithmetically from the wait-state count, plus a grant/readback model.
module tb_bus_cycle_sequencer;

   logic        CLK = 1'b0;
   logic        RESET, FETCH_REQ, DATA_REQ, DATA_WR, MEM_WAIT;
   logic [1:0]  DATA_SRC;
   logic [15:0] MEM_DATA_IN;

   logic        fack1, dack1, rd1, wr1, busy1;
   logic [1:0]  addr1;
   logic [15:0] rdata1;
   logic        fack0, dack0, rd0, wr0, busy0;
   logic [1:0]  addr0;
   logic [15:0] rdata0;

   bus_cycle_sequencer #(.WAIT_STATES(1)) dut1 (
      .CLK(CLK), .RESET(RESET), .FETCH_REQ(FETCH_REQ), .FETCH_ACK(fack1),
      .DATA_REQ(DATA_REQ), .DATA_WR(DATA_WR), .DATA_SRC(DATA_SRC), .DATA_ACK(dack1),
      .MEM_WAIT(MEM_WAIT), .MEM_DATA_IN(MEM_DATA_IN), .RDATA(rdata1),
      .ADDR_BUSX(addr1), .MEM_RD(rd1), .MEM_WR(wr1), .BUSY(busy1));

   bus_cycle_sequencer #(.WAIT_STATES(0)) dut0 (
      .CLK(CLK), .RESET(RESET), .FETCH_REQ(FETCH_REQ), .FETCH_ACK(fack0),
      .DATA_REQ(DATA_REQ), .DATA_WR(DATA_WR), .DATA_SRC(DATA_SRC), .DATA_ACK(dack0),
      .MEM_WAIT(MEM_WAIT), .MEM_DATA_IN(MEM_DATA_IN), .RDATA(rdata0),
      .ADDR_BUSX(addr0), .MEM_RD(rd0), .MEM_WR(wr0), .BUSY(busy0));

   always #5 CLK = ~CLK;

   int          ws_cur = 1;
   logic [6:0]  w_obs0, w_obs1, w_obs;
   logic [15:0] w_rdata;
   assign w_obs1  = {busy1, addr1, rd1, wr1, fack1, dack1};
   assign w_obs0  = {busy0, addr0, rd0, wr0, fack0, dack0};
   assign w_obs   = (ws_cur != 0) ? w_obs1 : w_obs0;
   assign w_rdata = (ws_cur != 0) ? rdata1 : rdata0;

   // Reference state: who was granted last and what RDATA should hold.
   bit          m_last_data;
   logic [15:0] m_rdata;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic apply_reset(input bit fr, input bit dr);
      @(negedge CLK);
      RESET = 1'b1; FETCH_REQ = fr; DATA_REQ = dr; DATA_WR = 1'b0;
      DATA_SRC = 2'd0; MEM_WAIT = 1'b0; MEM_DATA_IN = 16'h0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      m_last_data = 1'b1;
      m_rdata     = 16'h0000;
   endtask

   // One complete access starting from an IDLE-cycle negedge; checks every cycle
   // against the timeline IDLE, SETUP, STROBE x(ws+1+nw), DONE.
   task automatic do_access(input string tag, input bit fr, input bit dr, input bit wr,
                            input logic [1:0] src, input int nw, input logic [15:0] din,
                            input bit disturb, output bit win_f);
      bit         is_wr;
      logic [1:0] sel;
      int         last_k;
      logic [6:0] exp;
      win_f  = fr && (!dr || m_last_data);
      is_wr  = !win_f && wr;
      sel    = win_f ? 2'd0 : src;
      last_k = 3 + ws_cur + nw;
      FETCH_REQ = fr; DATA_REQ = dr; DATA_WR = wr; DATA_SRC = src;
      for (int k = 0; k <= last_k; k++) begin
         exp = 7'b0;
         if (k >= 1) exp = {1'b1, sel, 4'b0000};
         if (k >= 2 && k < last_k) exp[3:2] = {!is_wr, is_wr};
         if (k == last_k) exp[1:0] = {win_f, !win_f};
         n_checks++;
         if (w_obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d {busy,addr,rd,wr,fack,dack}: got %b want %b",
                     tag, k, w_obs, exp);
         end
         if (k == last_k) begin
            if (!is_wr) m_rdata = din;
            m_last_data = !win_f;
            n_checks++;
            if (w_rdata !== m_rdata) begin
               n_errors++;
               $display("FAIL %s rdata: got %h want %h", tag, w_rdata, m_rdata);
            end
         end
         MEM_WAIT    = 1'($urandom);
         MEM_DATA_IN = 16'($urandom);
         if (k >= 2 + ws_cur && k < last_k - 1) MEM_WAIT = 1'b1;
         if (k == last_k - 1) begin
            MEM_WAIT    = 1'b0;
            MEM_DATA_IN = din;
         end
         if (disturb && k >= 1 && k < last_k) begin
            DATA_SRC  = 2'($urandom);
            DATA_WR   = 1'($urandom);
            FETCH_REQ = 1'($urandom);
            DATA_REQ  = 1'($urandom);
         end
         if (disturb && k == last_k) begin
            FETCH_REQ = 1'b0;
            DATA_REQ  = 1'b0;
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_reset();
      apply_reset(1'b0, 1'b0);
      n_checks++;
      if (w_obs1 !== 7'b0 || w_obs0 !== 7'b0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b/%b want 0000000", w_obs1, w_obs0);
      end
      n_checks++;
      if (rdata1 !== 16'h0 || rdata0 !== 16'h0) begin
         n_errors++;
         $display("FAIL reset_rdata: got %h/%h want 0000", rdata1, rdata0);
      end
      @(negedge CLK);
      n_checks++;
      if (w_obs1 !== 7'b0 || w_obs0 !== 7'b0) begin
         n_errors++;
         $display("FAIL idle_no_req: got %b/%b want 0000000", w_obs1, w_obs0);
      end
   endtask

   task automatic test_fetch();
      bit w;
      ws_cur = 1;
      apply_reset(1'b0, 1'b0);
      do_access("fetch", 1'b1, 1'b0, 1'b1, 2'd3, 0, 16'hA55A, 1'b0, w);
      FETCH_REQ = 1'b0;
      n_checks++;
      if (w !== 1'b1) begin
         n_errors++;
         $display("FAIL fetch_grant: got %b want 1", w);
      end
   endtask

   task automatic test_data_write();
      bit w;
      ws_cur = 0;
      apply_reset(1'b0, 1'b0);
      do_access("ws0_read", 1'b0, 1'b1, 1'b0, 2'd1, 0, 16'h1234, 1'b0, w);
      do_access("ws0_write", 1'b0, 1'b1, 1'b1, 2'd2, 0, 16'hBEEF, 1'b0, w);
      DATA_REQ = 1'b0;
      n_checks++;
      if (rdata0 !== 16'h1234) begin
         n_errors++;
         $display("FAIL write_keeps_rdata: got %h want 1234", rdata0);
      end
   endtask

   task automatic test_back_to_back();
      bit w;
      ws_cur = 1;
      apply_reset(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         do_access("b2b", 1'b1, 1'b1, 1'b0, 2'd3, 0, 16'($urandom), 1'b0, w);
         n_checks++;
         if (w !== ((i % 2) == 0)) begin
            n_errors++;
            $display("FAIL b2b_alternate #%0d: fetch_won %b want %b", i, w, (i % 2) == 0);
         end
      end
      FETCH_REQ = 1'b0; DATA_REQ = 1'b0;
   endtask

   task automatic test_wait_read();
      bit w;
      ws_cur = 1;
      apply_reset(1'b0, 1'b0);
      do_access("wait_read", 1'b0, 1'b1, 1'b0, 2'd3, 3, 16'h5AA5, 1'b0, w);
      DATA_REQ = 1'b0;
   endtask

   task automatic test_mid_reset();
      ws_cur = 1;
      apply_reset(1'b0, 1'b0);
      DATA_REQ = 1'b1; DATA_WR = 1'b0; DATA_SRC = 2'd1; MEM_WAIT = 1'b1;
      MEM_DATA_IN = 16'hDEAD;
      repeat (2) @(negedge CLK);
      n_checks++;
      if (w_obs !== 7'b1011000) begin
         n_errors++;
         $display("FAIL mid_reset_pre: got %b want 1011000", w_obs);
      end
      RESET = 1'b1; DATA_REQ = 1'b0;
      @(negedge CLK);
      RESET = 1'b0;
      m_last_data = 1'b1; m_rdata = 16'h0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (w_obs !== 7'b0 || w_rdata !== m_rdata) begin
            n_errors++;
            $display("FAIL mid_reset_post %0d: got %b/%h want 0000000/%h", i, w_obs, w_rdata, m_rdata);
         end
         @(negedge CLK);
      end
   endtask

   task automatic test_src_change();
      bit w;
      ws_cur = 1;
      apply_reset(1'b0, 1'b0);
      do_access("src_hold_rd", 1'b0, 1'b1, 1'b0, 2'd1, 1, 16'h0F0F, 1'b1, w);
      do_access("src_hold_wr", 1'b0, 1'b1, 1'b1, 2'd2, 0, 16'hF0F0, 1'b1, w);
      do_access("fetch_drop", 1'b1, 1'b0, 1'b0, 2'd3, 2, 16'h7777, 1'b1, w);
   endtask

   task automatic test_random();
      bit w;
      logic [1:0] r;
      for (int pass = 0; pass < 2; pass++) begin
         ws_cur = (pass == 0) ? 1 : 0;
         apply_reset(1'b0, 1'b0);
         for (int i = 0; i < 20; i++) begin
            r = 2'($urandom_range(1, 3));
            do_access("random", r[0], r[1], 1'($urandom), 2'($urandom),
                      int'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), w);
         end
         FETCH_REQ = 1'b0; DATA_REQ = 1'b0;
      end
   endtask

   initial begin
      RESET = 1'b1; FETCH_REQ = 1'b0; DATA_REQ = 1'b0; DATA_WR = 1'b0;
      DATA_SRC = 2'd0; MEM_WAIT = 1'b0; MEM_DATA_IN = 16'h0;
      m_last_data = 1'b1; m_rdata = 16'h0;
      test_reset();
      test_fetch();
      test_data_write();
      test_back_to_back();
      test_wait_read();
      test_mid_reset();
      test_src_change();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_cycle_sequencer.md
# bus_cycle_sequencer

Sequences every memory bus cycle of the CPU core and arbitrates the address bus between the instruction-fetch unit and the data-access path. It owns the address bus multiplexer select, drives the memory read/write strobes with a configurable wait-state count, and returns a one-cycle acknowledge with captured read data to the winning requester. It sits between the control unit's request lines and the address bus multiplexer / memory interface.

## Interface
Parameters:
- WAIT_STATES, default 1: extra strobe cycles inserted per access; legal range 0..7.

Ports:
- CLK  in  1  single system clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- FETCH_REQ  in  1  instruction fetch request; address source is always PC.
- FETCH_ACK  out  1  one-cycle pulse: fetch complete, RDATA valid.
- DATA_REQ  in  1  data access request.
- DATA_WR  in  1  with DATA_REQ: 1 = write, 0 = read.
- DATA_SRC  in  2  address source for the data access, in ADDR_BUSX encoding.
- DATA_ACK  out  1  one-cycle pulse: data access complete; RDATA valid for reads.
- MEM_WAIT  in  1  memory-side wait; extends the strobe phase while high.
- MEM_DATA_IN  in  16  read data from memory.
- RDATA  out  16  registered read data.
- ADDR_BUSX  out  2  address mux select: 0 = PC, 1 = REG_A, 2 = REG_B, 3 = ALU.
- MEM_RD  out  1  read strobe, active high.
- MEM_WR  out  1  write strobe, active high.
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: ADDR_BUSX = 0, strobes low. Samples requests; requests are sampled only here.
  - Only FETCH_REQ high: grant fetch. Only DATA_REQ high: grant data. Neither: stay.
  - Both high: grant the requester not granted last (LAST_GRANT register). LAST_GRANT resets to "data", so the first contention goes to fetch.
  - On grant: latch op (fetch / data-read / data-write) and select (0 for fetch, DATA_SRC for data); -> SETUP.
- SETUP: 1 cycle. ADDR_BUSX = latched select; strobes low. Load wait counter with WAIT_STATES; -> STROBE.
- STROBE: ADDR_BUSX held. MEM_RD high for fetch/data-read, MEM_WR high for data-write, never both.
  - Counter nonzero: decrement, stay.
  - Counter zero and MEM_WAIT high: stay.
  - Counter zero and MEM_WAIT low: this is the last strobe cycle. Capture MEM_DATA_IN into RDATA on reads; -> DONE.
- DONE: strobes low, ADDR_BUSX held. Pulse FETCH_ACK or DATA_ACK for exactly 1 cycle. Update LAST_GRANT; -> IDLE.
- Latched op and select are immune to request or DATA_SRC changes after the grant.
- A request dropped mid-cycle does not abort the cycle: it completes and its ACK still pulses.
- RDATA is unchanged by writes and holds its value until the next read captures.
- Requesters hold REQ until ACK. A REQ still high in the IDLE cycle after ACK is a new request.

## Timing
- Reset values: state IDLE, ADDR_BUSX 0, MEM_RD 0, MEM_WR 0, FETCH_ACK 0, DATA_ACK 0, BUSY 0, RDATA 16'h0000, LAST_GRANT = data, counter 0.
- RESET mid-cycle: at the next edge, strobes drop and the state returns to IDLE; no ACK is issued.
- All outputs are registered.
- Request seen high in IDLE at edge 0:
  - SETUP during cycle 1.
  - STROBE during cycles 2 .. 2+WAIT_STATES+n, where n = cycles MEM_WAIT is high at counter zero.
  - ACK during the following cycle.
- Minimum request-to-ACK: WAIT_STATES+3 cycles. Full cycle including the return to IDLE: WAIT_STATES+4 cycles.
- The address is stable from SETUP through DONE. Strobes are never high in SETUP or DONE, giving address setup/hold of one cycle each.

## Test plan
- Fetch only, WAIT_STATES=1, MEM_DATA_IN=16'hA55A:
  - Expect ADDR_BUSX=0 in SETUP, MEM_RD high for exactly 2 cycles, FETCH_ACK pulses at cycle 4.
  - Expect RDATA=16'hA55A and DATA_ACK never high.
- Data write, DATA_SRC=2, WAIT_STATES=0:
  - Expect ADDR_BUSX=2 from SETUP through DONE, MEM_WR high 1 cycle, MEM_RD never high, DATA_ACK at cycle 3.
  - Expect RDATA unchanged.
- FETCH_REQ and DATA_REQ both held high continuously from reset:
  - Grants alternate fetch, data, fetch, data.
  - ACKs never overlap; BUSY drops for exactly 1 cycle between accesses.
- Data read, DATA_SRC=3, MEM_WAIT held high 3 cycles at counter zero:
  - Strobe phase lengthens by 3 cycles.
  - RDATA captures the MEM_DATA_IN value present on the cycle MEM_WAIT falls.
- Mid-cycle disturbances:
  - RESET asserted during STROBE: MEM_RD/MEM_WR low and state IDLE after the next edge, no ACK pulse.
  - DATA_SRC changed during STROBE: ADDR_BUSX stays at the latched value.
